// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: FSM states, word geometry and default reset PC.
// The HALT state only exists when FETCH_MISALIGN_CHK_EN is defined.
package fetch_pkg;
  localparam int XLEN = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    HALT = 2'd2
`endif
  } fetch_state_t;

  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INSTR_BYTES);
  endfunction
endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/grant/response plus the decode valid/ready port.
// master = fetch unit side, slave = memory/decode side.
interface instr_fetch_unit_if;
  import fetch_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] Instruction;
  logic [XLEN-1:0] instr_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output instr_valid, Instruction, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  instr_valid, Instruction, instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush and occupancy count; head is registered storage, a push is visible next cycle.
// Push and pop may coincide at any occupancy; push into a full FIFO without a pop is ignored.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic                     vld,
  output logic [WIDTH-1:0]         head_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  // When full, the slot being written is the one being popped, so the pair is safe.
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '{default: '0};
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  assign vld      = (count != '0);
  assign head_dat = mem[rd_ptr];
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, credit-limited in-order fetches, {word, pc} buffering, redirect flush.
// Misaligned-target HALT and the misalign port exist only with FETCH_MISALIGN_CHK_EN.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  instr_fetch_unit_if.master    bus,
  input  logic                  redirect,
  input  logic [XLEN-1:0]       redirect_pc
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic                  misalign
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t      state;
  logic [XLEN-1:0]   pc;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     drop;
  logic [CW-1:0]     occupancy;
  logic [CW-1:0]     tag_count;
  logic              tag_vld;
  logic [XLEN-1:0]   tag_pc;
  logic [XLEN-1:0]   redirect_tgt;
  logic [2*XLEN-1:0] head;
  logic              grant;
  logic              rsp_ok;
  logic              push;
  logic              pop;

`ifdef FETCH_MISALIGN_CHK_EN
  logic bad_target;
  assign redirect_tgt = redirect_pc;
  assign bad_target   = (redirect_pc[1:0] != 2'b00);
`else
  assign redirect_tgt = redirect_pc & ~XLEN'(INSTR_BYTES - 1);
`endif

  // Outstanding includes responses still owed to a flushed stream, so credit stays honest.
  assign bus.imem_req  = (state == RUN) && !redirect &&
                         (({1'b0, occupancy} + {1'b0, outstanding}) < (CW + 1)'(DEPTH));
  assign bus.imem_addr = pc;

  assign grant  = bus.imem_req && bus.imem_gnt;
  assign rsp_ok = bus.imem_rvalid && (outstanding != '0);
  assign push   = rsp_ok && !redirect && (drop == '0);
  assign pop    = bus.instr_valid && bus.instr_ready && !redirect;

  fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect),
    .push     (grant),
    .push_dat (pc),
    .pop      (push),
    .vld      (tag_vld),
    .head_dat (tag_pc),
    .count    (tag_count)
  );

  fetch_fifo #(.WIDTH(2 * XLEN), .DEPTH(DEPTH)) u_instr_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect),
    .push     (push),
    .push_dat ({bus.imem_rdata, tag_pc}),
    .pop      (pop),
    .vld      (bus.instr_valid),
    .head_dat (head),
    .count    (occupancy)
  );

  assign {bus.Instruction, bus.instr_pc} = head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
`ifdef FETCH_MISALIGN_CHK_EN
      misalign    <= 1'b0;
`endif
    end else begin
      outstanding <= outstanding + CW'(grant) - CW'(rsp_ok);
      if (redirect) begin
        pc   <= redirect_tgt;
        drop <= outstanding - CW'(rsp_ok);
      end else begin
        if (grant) begin
          pc <= next_pc(pc);
        end
        if (rsp_ok && (drop != '0)) begin
          drop <= drop - CW'(1);
        end
      end

      case (state)
        BOOT:    state <= RUN;
        default: state <= state;
      endcase
`ifdef FETCH_MISALIGN_CHK_EN
      // HALT is terminal until reset; leftover responses drain through drop.
      if (redirect && bad_target) begin
        state    <= HALT;
        misalign <= 1'b1;
      end
`endif
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(bus.imem_rvalid && (outstanding == '0)));
      assert (!push || tag_vld);
      assert (tag_count <= outstanding);
    end
  end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage directly upstream of `Register_Bank`. It holds the program counter, issues in-order word fetches to instruction memory over a request/grant/response handshake, and buffers returned words in a small FIFO. It presents them to decode with a valid/ready handshake: `Instruction` feeds the register bank's `Instruction` input. Branch/jump redirects flush all in-flight and buffered fetches.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset
- `DEPTH`, 2, FIFO entries and maximum in-flight requests; power of 2, ≥2
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `imem_req`  out  1  fetch request
- `imem_addr`  out  32  fetch address; equals PC
- `imem_gnt`  in  1  memory accepts the request this cycle
- `imem_rvalid`  in  1  response word valid; in order, at most one per cycle
- `imem_rdata`  in  32  response word
- `redirect`  in  1  taken branch/jump, single-cycle pulse
- `redirect_pc`  in  32  new fetch target
- `instr_valid`  out  1  FIFO head valid
- `instr_ready`  in  1  decode consumes the head
- `Instruction`  out  32  FIFO head word
- `instr_pc`  out  32  address of the head word
- `misalign`  out  1  sticky misaligned-target flag (only with `FETCH_MISALIGN_CHK_EN`)

## Operation
- FSM states: BOOT → RUN → HALT.
  - BOOT lasts one cycle after reset release and issues no request.
  - HALT is reachable only with the macro and exits only on reset.
- Credit rule:
  - `imem_req` = RUN && !redirect && (occupancy + outstanding < DEPTH).
  - occupancy = FIFO entry count. outstanding = granted requests whose responses have not yet returned.
- Handshakes:
  - On `imem_req && imem_gnt`: PC += 4 (wraps modulo 2^32), and outstanding increments.
  - On `imem_rvalid`: outstanding decrements. The {word, pc} pair is pushed unless `drop` > 0, in which case `drop` decrements and the word is discarded.
  - A pc-tag FIFO is written at grant time and paired with the response on push.
  - Pop on `instr_valid && instr_ready`. Simultaneous push and pop is legal at any occupancy.
- Redirect, in the same cycle:
  - FIFO and tag FIFO flushed.
  - `drop` ← outstanding minus any response arriving that cycle.
  - PC ← `redirect_pc`.
  - No request is issued that cycle.
  - A response arriving in the redirect cycle is discarded.
  - Decode must not pop in the redirect cycle; a pop there is ignored.
- Redirect while `drop` > 0 accumulates the newly outstanding count.
- The credit rule guarantees no FIFO overflow. A response with outstanding = 0 is a protocol error: ignore it, and flag it with an assertion.

## Timing
- Reset values:
  - `imem_req` 0, `imem_addr` `RESET_PC`
  - `instr_valid` 0, `Instruction` 0, `instr_pc` 0
  - `misalign` 0, state BOOT, all counters 0
- `imem_req`/`imem_addr` are combinational from registered state.
- FIFO outputs are registered; no rvalid-to-output bypass. A word is visible the cycle after its `imem_rvalid`.
- With 1-cycle memory latency and `instr_ready`=1:
  - first `instr_valid` 3 cycles after reset release
  - then one instruction per cycle
- First request after a redirect is in the following cycle, addressed to `redirect_pc`.
- Reset asserted mid-operation immediately clears all state. In-flight responses after release are not tracked; the memory must be reset together with this block.

## Configuration
- `FETCH_MISALIGN_CHK_EN` defined:
  - A redirect with `redirect_pc[1:0]` ≠ 0 sets `misalign` and enters HALT.
  - In HALT, `imem_req` = 0; the FIFO still drains and responses are dropped.
- Not defined: the `misalign` port is absent, HALT is removed, and `redirect_pc[1:0]` is forced to 0.

## Structure
- Shared package `fetch_pkg`: state enum (BOOT/RUN/HALT), `XLEN`=32, `INSTR_BYTES`=4, `RESET_PC_DEFAULT`.
- One sub-module, `fetch_fifo`: parameterised sync FIFO with flush, count output, and simultaneous push/pop; instantiated for {word, pc}.
- PC-tag FIFO reuses `fetch_fifo`.

## Test plan
- Reset release → `imem_addr`=0x0 and `instr_valid`=0 during BOOT. First grant is at 0x0, and `instr_pc` sequence is 0x0, 0x4, 0x8 in consecutive cycles.
- `instr_ready`=0 with 1-cycle memory → exactly 2 grants, then `imem_req`=0. Raising ready yields 0x0 then 0x4 with no loss or duplication.
- Memory latency 3, gnt always 1 → never more than 2 outstanding; `instr_pc` remains strictly +4 ordered.
- Redirect to 0x100 with 2 outstanding → both stale responses dropped. Next `instr_pc`=0x100, followed by 0x104.
- Macro on: redirect to 0x102 → `misalign`=1 the next cycle and `imem_req` stays 0 until `rst_n` is asserted. Macro off: fetch resumes at 0x100.
- `rst_n` asserted asynchronously mid-stream → outputs return to reset values without waiting for a clock edge.
